// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_ctrl : iterative RV32M shift-add multiply / restoring divide   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c_out,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;

  logic              is_div;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg_in;
  logic              b_neg_in;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result;

  // Request decode: operand signedness, magnitudes and divide corner cases.
  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in = a_signed && a_in[XLEN-1];
    b_neg_in = b_signed && b_in[XLEN-1];
    a_mag    = a_neg_in ? -a_in : a_in;
    b_mag    = b_neg_in ? -b_in : b_in;
    div_zero = is_div && (b_in == '0);
    div_ovf  = is_div && !funct3[0] && (a_in == INT_MIN) && (b_in == '1);
    if (div_zero) special_res = funct3[1] ? a_in : '1;
    else          special_res = funct3[1] ? '0 : a_in;
  end

  // One iteration step for each algorithm; lo doubles as multiplier / quotient.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    quo_fix  = (neg_a ^ neg_b) ? -lo : lo;
    rem_fix  = neg_a ? -hi : hi;
    case (op)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo_fix;
      default:                result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      c_out     <= '0;
      rd_out    <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op       <= funct3;
            rd_out   <= rd_in;
            neg_a    <= a_neg_in;
            neg_b    <= b_neg_in;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (div_zero || div_ovf) begin
              c_out     <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              hi    <= '0;
              lo    <= is_div ? a_mag : b_mag;
              opnd  <= is_div ? b_mag : a_mag;
              count <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          c_out     <= result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// tb_muldiv_ctrl : scoreboard bench for the RV32M multiply/divide sequencer.
module tb_muldiv_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic [4:0]      rd_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] c_out;
  logic [4:0]      rd_out;
  logic            busy;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .funct3   (funct3),
    .a_in     (a_in),
    .b_in     (b_in),
    .rd_in    (rd_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c_out    (c_out),
    .rd_out   (rd_out),
    .busy     (busy)
  );

  typedef struct {
    logic [31:0] c;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb2;
    logic signed [63:0] ub;
    logic [63:0]        p;
    logic               ovf;
    logic [31:0]        r;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'b001: begin p = sa * sb2; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) ||
                    (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // Issue one op, wait for its result, hold DONE for 'hold' cycles, then retire it.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    exp_t e;
    int   cyc;
    logic bsy_ok;
    e.c   = model(f, a, b);
    e.rd  = rd;
    e.lat = is_special(f, a, b) ? 1 : XLEN + 2;
    check("in_ready_idle", 32'(in_ready), 1);
    out_ready = (hold == 0);
    funct3 = f; a_in = a; b_in = b; rd_in = rd; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    bsy_ok = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (!busy || in_ready) bsy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_calc", 32'(bsy_ok), 1);
    check("latency", cyc, e.lat);
    check("busy_done", 32'(busy), 1);
    e = sb.pop_front();
    check("c_out", c_out, e.c);
    check("rd_out", 32'(rd_out), 32'(e.rd));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a_in = $urandom;
      b_in = $urandom;
      funct3 = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_c_out", c_out, e.c);
      check("hold_rd_out", 32'(rd_out), 32'(e.rd));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_in_ready", 32'(in_ready), 1);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    funct3 = 3'b0; a_in = '0; b_in = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_c_out", c_out, 0);
    check("rst_rd_out", 32'(rd_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd6, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
    run_op(3'b101, 32'd100, 32'd7, 5'd9, 0);
    run_op(3'b111, 32'd100, 32'd7, 5'd10, 0);
    run_op(3'b101, 32'h1234, 32'd0, 5'd11, 0);
    run_op(3'b111, 32'h1234, 32'd0, 5'd12, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
    for (int i = 0; i < 8; i++)
      run_op(3'(i), $urandom, $urandom, 5'($urandom_range(1, 31)), 0);
    run_op(3'b101, 32'd100, 32'd7, 5'd9, 5);

    // Flush mid-divide: the result must never appear.
    funct3 = 3'b100; a_in = 32'd1000; b_in = 32'd3; rd_in = 5'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush_pre_busy", 32'(busy), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    check("flush_out_valid", 32'(out_valid), 0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("flush_no_result", 32'(seen), 0);
    run_op(3'b000, 32'd3, 32'd4, 5'd13, 0);

    // Flush in IDLE blocks a same-cycle request.
    funct3 = 3'b000; a_in = 32'd5; b_in = 32'd5; rd_in = 5'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 32'(busy), 0);
    check("idle_flush_in_ready", 32'(in_ready), 1);

    // Reset mid-CALC.
    funct3 = 3'b000; a_in = 32'd5; b_in = 32'd6; rd_in = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_c_out", c_out, 0);
    check("mid_rst_rd_out", 32'(rd_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    run_op(3'b011, 32'h0001_0000, 32'h0003_0000, 5'd22, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
